pc_sequencer: RTL and testbench

//  Fetch-stage controller for Program_Counter: computes next_pc and drives pc_write, IF/ID write/flush
//  and ID/EX flush. Arbitrates redirect, load-use stall, imem wait and halt; holds a boot sequence.

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: picks next_pc and drives PC/IF-ID/ID-EX enables and flushes.
// Arbitrates EX redirects, load-use stalls, imem waits and halt, after a short boot hold.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
  parameter int unsigned BOOT_HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        load_use_hazard,
  input  logic        imem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] next_pc,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [15:0] stall_count
);

  // state | meaning
  // BOOT  | hold fetch at RESET_VECTOR, pipeline flushed, inputs ignored
  // RUN   | normal fetch with redirect > stall > imem wait > halt priority
  // FLUSH | one cycle after a redirect; ID holds a bubble so load-use is ignored
  // HALT  | fetch frozen, older instructions drain; a draining branch may still move PC
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [15:0] BOOT_INIT = 16'(BOOT_HOLD_CYCLES);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] boot_cnt;
  logic        stall_inc;
  logic [31:0] redirect_pc;
  logic        stall_now;

  assign redirect_pc = {redirect_target[31:2], 2'b00};
  assign stall_now   = (load_use_hazard && (state == S_RUN)) || !imem_ready;

  always_comb begin
    state_nxt  = state;
    next_pc    = pc;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    stall_inc  = 1'b0;
    case (state)
      S_BOOT: begin
        next_pc    = RESET_VECTOR;
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (boot_cnt <= 16'd1) state_nxt = S_RUN;
      end
      S_RUN, S_FLUSH: begin
        if (redirect_valid) begin
          next_pc    = redirect_pc;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_nxt  = S_FLUSH;
        end else if (stall_now) begin
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
          state_nxt  = S_RUN;
        end else if (halt_req) begin
          ifid_flush = 1'b1;
          state_nxt  = S_HALT;
        end else begin
          next_pc    = pc + 32'd4;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          state_nxt  = S_RUN;
        end
      end
      S_HALT: begin
        halted     = 1'b1;
        ifid_flush = 1'b1;
        if (redirect_valid) begin
          next_pc  = redirect_pc;
          pc_write = 1'b1;
        end
        if (resume) state_nxt = S_RUN;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      boot_cnt    <= BOOT_INIT;
      stall_count <= 16'd0;
    end else begin
      state <= state_nxt;
      if ((state == S_BOOT) && (boot_cnt != 16'd0)) boot_cnt <= boot_cnt - 16'd1;
      // saturate rather than wrap so long stalls stay visible
      if (stall_inc && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a simple Program_Counter model in the loop.
module tb_pc_sequencer;

  logic        clk = 1'b1;
  logic        rst;
  logic [31:0] pc = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        load_use_hazard;
  logic        imem_ready;
  logic        halt_req;
  logic        resume;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        halted;
  logic [15:0] stall_count;

  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = 32'd0;

  int checks = 0;
  int failures = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .BOOT_HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .load_use_hazard(load_use_hazard), .imem_ready(imem_ready),
    .halt_req(halt_req), .resume(resume),
    .next_pc(next_pc), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Program_Counter stand-in; pc_set lets the bench jump to a chosen address
  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_val;
    else if (pc_write) pc <= next_pc;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic [31:0] npc, input logic pw,
                           input logic iw, input logic ifl, input logic idf, input logic hl);
    check_val({tag, ".next_pc"}, next_pc, npc);
    check_val({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, pw});
    check_val({tag, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, iw});
    check_val({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, ifl});
    check_val({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, idf});
    check_val({tag, ".halted"}, {31'd0, halted}, {31'd0, hl});
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    load_use_hazard = 1'b0;
    imem_ready = 1'b1;
    halt_req = 1'b0;
    resume = 1'b0;

    // boot sequence
    #12;
    check_ctl("rst", 32'h0, 1, 0, 1, 1, 0);
    check_val("rst.stall_count", {16'd0, stall_count}, 32'd0);
    #3 rst = 1'b0;
    #2 check_ctl("boot1", 32'h0, 1, 0, 1, 1, 0);
    @(negedge clk);
    check_ctl("boot2", 32'h0, 1, 0, 1, 1, 0);
    @(negedge clk);
    check_ctl("run4", 32'h4, 1, 1, 0, 0, 0);
    @(negedge clk);
    check_ctl("run8", 32'h8, 1, 1, 0, 0, 0);
    @(negedge clk);
    check_ctl("run12", 32'hC, 1, 1, 0, 0, 0);

    // load-use stall
    next_cycle();
    pc_set = 1'b1; pc_set_val = 32'h20;
    next_cycle();
    pc_set = 1'b0; load_use_hazard = 1'b1;
    @(negedge clk);
    check_ctl("lu", 32'h20, 0, 0, 0, 1, 0);
    next_cycle();
    load_use_hazard = 1'b0;
    check_val("lu.stall_count", {16'd0, stall_count}, 32'd1);
    @(negedge clk);
    check_ctl("lu.after", 32'h24, 1, 1, 0, 0, 0);

    // redirect beats load-use, then FLUSH ignores load-use
    next_cycle();
    pc_set = 1'b1; pc_set_val = 32'h40;
    next_cycle();
    pc_set = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h103; load_use_hazard = 1'b1;
    @(negedge clk);
    check_ctl("redir", 32'h100, 1, 1, 1, 1, 0);
    next_cycle();
    redirect_valid = 1'b0;
    check_val("redir.stall_count", {16'd0, stall_count}, 32'd1);
    @(negedge clk);
    check_ctl("flush", 32'h104, 1, 1, 0, 0, 0);
    next_cycle();
    load_use_hazard = 1'b0;
    check_val("flush.stall_count", {16'd0, stall_count}, 32'd1);

    // imem wait beats held halt_req, then halt
    halt_req = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    check_ctl("imem", 32'h104, 0, 0, 0, 1, 0);
    next_cycle();
    next_cycle();
    imem_ready = 1'b1;
    check_val("imem.stall_count", {16'd0, stall_count}, 32'd3);
    @(negedge clk);
    check_ctl("halt.take", 32'h104, 0, 0, 1, 0, 0);
    next_cycle();
    halt_req = 1'b0;
    @(negedge clk);
    check_ctl("halt", 32'h104, 0, 0, 1, 0, 1);
    next_cycle();
    redirect_valid = 1'b1; redirect_target = 32'h202;
    @(negedge clk);
    check_ctl("halt.redir", 32'h200, 1, 0, 1, 0, 1);
    next_cycle();
    redirect_valid = 1'b0; resume = 1'b1;
    @(negedge clk);
    check_ctl("resume", 32'h200, 0, 0, 1, 0, 1);
    next_cycle();
    resume = 1'b0;
    @(negedge clk);
    check_ctl("resumed", 32'h204, 1, 1, 0, 0, 0);
    next_cycle();
    resume = 1'b1;
    @(negedge clk);
    check_ctl("resume.run", 32'h208, 1, 1, 0, 0, 0);

    // wrap at top of address space
    next_cycle();
    resume = 1'b0; pc_set = 1'b1; pc_set_val = 32'hFFFF_FFFC;
    next_cycle();
    pc_set = 1'b0;
    @(negedge clk);
    check_ctl("wrap", 32'h0, 1, 1, 0, 0, 0);

    // async reset while halted
    next_cycle();
    halt_req = 1'b1;
    next_cycle();
    halt_req = 1'b0; pc_set = 1'b1; pc_set_val = 32'h300;
    next_cycle();
    pc_set = 1'b0;
    @(negedge clk);
    check_ctl("halt2", 32'h300, 0, 0, 1, 0, 1);
    #2 rst = 1'b1;
    #1 check_ctl("rst.halt", 32'h0, 1, 0, 1, 1, 0);
    check_val("rst.halt.stall_count", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    check_ctl("reboot", 32'h0, 1, 0, 1, 1, 0);
    next_cycle();

    // stall counter saturation
    load_use_hazard = 1'b1;
    repeat (65534) next_cycle();
    check_val("sat.fffe", {16'd0, stall_count}, 32'h0000_FFFE);
    repeat (10) next_cycle();
    check_val("sat.ffff", {16'd0, stall_count}, 32'h0000_FFFF);
    repeat (4456) next_cycle();
    check_val("sat.hold", {16'd0, stall_count}, 32'h0000_FFFF);
    load_use_hazard = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
